clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller. Derives one divided clock from the 100 MHz system clock, with a programmable divide ratio, high time and optional half-cycle high extension.
- Reconfiguration uses a valid/ready handshake. New settings are applied only at a period boundary, so clk_out is glitch-free.
- Replaces fixed-ratio divider instances wherever software or another FSM must retune a derived clock at runtime.

Parameters:
- CNT_W, 8, width of divide/high counters and config fields
- DEF_DIV, 5, divide ratio loaded at reset
- DEF_HIGH, 2, high time (input cycles) loaded at reset

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  reset
- en  input  1  run request for divided clock
- cfg_valid  input  1  config offer
- cfg_ready  output  1  controller can accept config (no config pending)
- cfg_div  input  CNT_W  divide ratio N (period = N input cycles)
- cfg_high  input  CNT_W  high time H in input cycles
- cfg_half  input  1  extend high time by half an input cycle
- clk_out  output  1  divided clock
- tick  output  1  one-cycle pulse, high in the first input cycle of each period
- cfg_err  output  1  one-cycle pulse, rejected config
- running  output  1  high in RUN or DRAIN

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=IDLE, cnt=0, out_p=0, out_n=0, tick=0, cfg_err=0, cfg_ready=1, pending=0, running=0.
  - Active config: div=DEF_DIV, high=DEF_HIGH, half=0.
  - out_n is a negedge flop; it clears on any negedge where rst=1.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cnt=0, out_p=0.
  - en=1 at a posedge → RUN, with cnt<=0, out_p<=1, tick<=1. clk_out rises on that same edge.
- RUN:
  - Each posedge: cnt <= (cnt==div-1) ? 0 : cnt+1.
  - out_p <= (next cnt < high).
  - tick <= (next cnt == 0).
  - en=0 sampled → DRAIN; counting continues.
- DRAIN:
  - Counts exactly as RUN until the wrap edge (cnt==div-1). At that edge → IDLE with cnt=0, out_p=0, tick=0.
  - en=1 sampled in DRAIN → RUN with no gap or phase change.
- Half extension:
  - out_n <= out_p at negedge clk.
  - clk_out = out_p | (half & out_n), i.e. the falling edge is delayed by half an input cycle.
  - clk_out is low in IDLE apart from that trailing half cycle.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at a posedge.
  - Valid config must satisfy 2 ≤ div and 1 ≤ high ≤ div-1.
    - Valid: latched into pending; cfg_ready<=0.
    - Invalid: discarded; cfg_err<=1 for exactly one cycle; cfg_ready stays 1; active config unchanged.
- Config apply:
  - In RUN/DRAIN, pending loads into the active config on the wrap edge. The new cnt=0 cycle already uses the new high/half. cfg_ready<=1 on the same edge.
  - In IDLE, pending loads on the next posedge, including the edge that enters RUN; the first period then uses the new config.
  - A config accepted on a wrap edge is not applied until the following wrap.
- Glitch-freedom: at every wrap, cnt=div-1 ≥ high, so out_p=out_n=0 before the config change.
- Reset mid-operation: all state returns to reset values at that posedge, and any pending config is lost.
- Width rules: comparisons are unsigned CNT_W-bit; cnt never exceeds div-1.

Test Plan:
- Reset, en=1, defaults (100 MHz clk) → clk_out period 50 ns, high 20 ns; tick every 5 cycles, coincident with clk_out rise; running=1.
- Mid-period: cfg div=10 high=5 half=0 → cfg_ready=0 until boundary; current 50 ns period completes; then 100 ns period, 50 ns high.
- cfg div=5 high=1 half=1 → high 15 ns, low 35 ns; no glitch at the switch boundary.
- Invalid configs (div=1; high=0; high=5 with div=5) → cfg_err one-cycle pulse each, cfg_ready stays 1, waveform unchanged.
- en dropped at cnt=1 → period finishes (high 20 ns, then low to cnt=4), then IDLE, clk_out=0. en re-raised at cnt=3 in DRAIN → continuous period, no gap.
- rst asserted mid-RUN with config pending → next edge clk_out=0, state IDLE. Restart gives 50 ns/20 ns defaults; pending config not applied.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable glitch-free clock divider with valid/ready reconfiguration
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 5,
    parameter int DEF_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_half,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_err,
    output logic             running
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic             half;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic             pend_half;
    logic             pending;
    logic             out_p;
    logic             out_n;

    logic             wrap;
    logic             apply;
    logic             cfg_ok;
    logic             cfg_take;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] high_nxt;

    always_comb begin
        wrap     = (cnt == div - ONE);
        cnt_nxt  = wrap ? '0 : cnt + ONE;
        // Pending config lands at a period boundary, or at any edge while idle.
        apply    = pending && ((state == IDLE) || wrap);
        high_nxt = apply ? pend_high : high;
        cfg_ok   = (cfg_div >= TWO) && (cfg_high != '0) && (cfg_high < cfg_div);
        cfg_take = cfg_valid && cfg_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_p     <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            pending   <= 1'b0;
            running   <= 1'b0;
            div       <= CNT_W'(DEF_DIV);
            high      <= CNT_W'(DEF_HIGH);
            half      <= 1'b0;
            pend_div  <= '0;
            pend_high <= '0;
            pend_half <= 1'b0;
        end else begin
            tick    <= 1'b0;
            cfg_err <= 1'b0;

            if (apply) begin
                div       <= pend_div;
                high      <= pend_high;
                half      <= pend_half;
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end

            // cfg_ready is the inverse of pending, so a transfer never collides with apply.
            if (cfg_take) begin
                if (cfg_ok) begin
                    pend_div  <= cfg_div;
                    pend_high <= cfg_high;
                    pend_half <= cfg_half;
                    pending   <= 1'b1;
                    cfg_ready <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    out_p <= 1'b0;
                    if (en) begin
                        state   <= RUN;
                        out_p   <= 1'b1;
                        tick    <= 1'b1;
                        running <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if ((state == DRAIN) && !en && wrap) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        out_p   <= 1'b0;
                        tick    <= 1'b0;
                        running <= 1'b0;
                    end else begin
                        state   <= en ? RUN : DRAIN;
                        cnt     <= cnt_nxt;
                        out_p   <= (cnt_nxt < high_nxt);
                        tick    <= (cnt_nxt == '0);
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    out_p   <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Half-cycle extension: trailing copy of out_p, sampled on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            out_n <= 1'b0;
        end else begin
            out_n <= out_p;
        end
    end

    assign clk_out = out_p | (half & out_n);

endmodule
